// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port BRAM arbiter shared by the program loader, the
// instruction fetch stage and the execute-stage load/store unit.
// Fixed priority loader > data > fetch, combinational grants and command port,
// and an RD_LAT-deep {valid, owner} pipe that steers read data back to the
// requester that issued the read.
// Optional feature: define MEM_ARB_FAIRNESS_EN to promote a starved fetch
// requester over data after STARVE_MAX consecutive denied cycles.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstn,
  // loader write port
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  // execute-stage data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // fetch read port
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  // BRAM command port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned LAST = RD_LAT - 1;

  // Reject parameter values the return pipe cannot represent
  if (RD_LAT == 0 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("mem_arbiter: RD_LAT must be in 1..4");
  end
  if (STARVE_MAX == 0) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

  // Fetch may compete only when it is not being flushed this cycle
  logic f_elig;
  logic promote;

  assign f_elig = f_req & ~f_flush;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;

  assign promote = (starve_cnt >= CNT_W'(STARVE_MAX));

  // Count consecutive denied fetch cycles, saturating at STARVE_MAX
  always_comb begin
    starve_nxt = starve_cnt;
    if (!f_req || f_gnt) begin
      starve_nxt = '0;
    end else if (!f_flush && (starve_cnt < CNT_W'(STARVE_MAX))) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end
`else
  // Strict priority: fetch is never promoted
  assign promote = 1'b0;
`endif

  // Grant selection; reset holds every grant low
  always_comb begin
    ld_gnt = 1'b0;
    d_gnt  = 1'b0;
    f_gnt  = 1'b0;
    if (rstn) begin
      if (ld_req) begin
        ld_gnt = 1'b1;
      end else if (promote && f_elig) begin
        f_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (f_elig) begin
        f_gnt = 1'b1;
      end
    end
  end

  // BRAM command port mirrors the granted request; write data is zero on reads
  always_comb begin
    mem_en    = ld_gnt | d_gnt | f_gnt;
    mem_we    = ld_gnt | (d_gnt & d_we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (d_gnt) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_wdata = d_wdata;
      end
    end else if (f_gnt) begin
      mem_addr = f_addr;
    end
  end

  // Return pipe: stage 0 holds last cycle's grant, stage LAST is the return stage
  logic [RD_LAT-1:0] sr_valid;
  logic [RD_LAT-1:0] sr_fetch;
  logic [RD_LAT-1:0] kept;
  logic [RD_LAT-1:0] valid_nxt;
  logic [RD_LAT-1:0] fetch_nxt;
  logic              rd_new;

  // A flush kills every fetch-owned entry, including the one returning now
  assign kept   = f_flush ? (sr_valid & ~sr_fetch) : sr_valid;
  assign rd_new = (d_gnt & ~d_we) | f_gnt;

  if (RD_LAT > 1) begin : g_deep
    assign valid_nxt = {kept[RD_LAT-2:0], rd_new};
    assign fetch_nxt = {sr_fetch[RD_LAT-2:0], f_gnt};
  end else begin : g_single
    assign valid_nxt = rd_new;
    assign fetch_nxt = f_gnt;
  end

  // Return pipe register; reset drops all in-flight reads
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_valid <= '0;
      sr_fetch <= '0;
    end else begin
      sr_valid <= valid_nxt;
      sr_fetch <= fetch_nxt;
    end
  end

  // Steer BRAM read data to the owner of the returning entry
  assign d_rvalid = kept[LAST] & ~sr_fetch[LAST];
  assign f_rvalid = kept[LAST] &  sr_fetch[LAST];
  assign d_rdata  = d_rvalid ? mem_rdata : '0;
  assign f_rdata  = f_rvalid ? mem_rdata : '0;
  assign busy     = |sr_valid;

endmodule
